// File: rtl/writeback_regfile.sv
// Writeback side of the register file: an in-order write buffer drains one entry
// per cycle into the 32x32 architectural array, with youngest-entry read bypass.
module writeback_regfile #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_dst,
  input  logic [31:0]              wb_data,
  input  logic                     commit_stall,
  input  logic [4:0]               rd_addr1,
  output logic [31:0]              rd_data1,
  input  logic [4:0]               rd_addr2,
  output logic [31:0]              rd_data2,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [4:0]  dst_q  [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] regs_q [32];

  logic        push;
  logic        pop;
  logic [4:0]  head_dst;
  logic [31:0] head_data;

  assign wb_ready  = (count_q != CW'(DEPTH));
  assign push      = wb_valid && wb_ready;
  assign pop       = (count_q != '0) && !commit_stall;
  assign head_dst  = dst_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot contents need no reset: occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[wr_ptr_q]  <= wb_dst;
      data_q[wr_ptr_q] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (pop && (head_dst != 5'd0)) begin
      regs_q[head_dst] <= head_data;
    end
  end

  // Slot gi is occupied when its distance from the head is below the count.
  logic [DEPTH-1:0] occ;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_occ
      logic [AW-1:0] off;
      assign off     = AW'(gi) - rd_ptr_q;
      assign occ[gi] = ({1'b0, off} < count_q);
    end
  endgenerate

  always_comb begin
    pending = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (occ[j]) pending[dst_q[j]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  logic [4:0]  rd_addr_w [2];
  logic [31:0] rd_data_w [2];

  assign rd_addr_w[0] = rd_addr1;
  assign rd_addr_w[1] = rd_addr2;
  assign rd_data1     = rd_data_w[0];
  assign rd_data2     = rd_data_w[1];

  // Walk from head to tail so the youngest matching entry overrides older ones.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [AW-1:0] idx;
      always_comb begin
        idx           = rd_ptr_q;
        rd_data_w[gi] = regs_q[rd_addr_w[gi]];
        for (int k = 0; k < DEPTH; k++) begin
          idx = rd_ptr_q + AW'(k);
          if ((CW'(k) < count_q) && (dst_q[idx] == rd_addr_w[gi]))
            rd_data_w[gi] = data_q[idx];
        end
        if (rd_addr_w[gi] == 5'd0) rd_data_w[gi] = '0;
      end
    end
  endgenerate

endmodule
